// File: rtl/line_burst_sched.sv
// line_burst_sched: per-frame scheduler splitting each line into full bursts plus a tail burst
// Optional feature macro: SCHED_ABORT_EN (adds abort input and aborted output)
module line_burst_sched #(
   parameter int LSIZE     = 16,
   parameter int VSIZE     = 12,
   parameter int BURST_LEN = 64,
   parameter int SETTLE    = 3
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [LSIZE-1:0] line_beats,
   input  logic [VSIZE-1:0] vactive,
   output logic             req,
   output logic [7:0]       req_len,
   input  logic             req_ack,
   input  logic             xfer_done,
`ifdef SCHED_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             new_base,
   output logic             burst_done,
   output logic             tail_done,
   output logic             busy,
   output logic             frame_done,
   output logic [VSIZE-1:0] line_cnt
);
   typedef enum logic [2:0] {IDLE, BASE, REQ, WAIT, PULSE, GAP, DONE} state_t;
   state_t state;
   logic [LSIZE-1:0] nf, r, full_cnt;
   logic [VSIZE-1:0] v;
   logic [7:0] gap_cnt;
   logic tail_issued, cur_tail, phantom, seen, abt_pend;
   logic abt, ack, frame_end, full_left, tail_left, abort_exit;

`ifdef SCHED_ABORT_EN
   assign abt = abort;
`else
   assign abt = 1'b0;
`endif

   // an exact-multiple line takes the REQ/WAIT path as a phantom burst so its tail_done keeps the same spacing
   assign ack        = phantom || req_ack;
   assign frame_end  = line_cnt == v || (nf == '0 && r == '0);
   assign full_left  = full_cnt < nf;
   assign tail_left  = r != '0 && !tail_issued;
   assign abort_exit = (state == REQ && !ack && abt) || (state == GAP && abt) || (state == PULSE && abt_pend);

   // frame sequencer with registered outputs
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req         <= 1'b0;
         req_len     <= '0;
         new_base    <= 1'b0;
         burst_done  <= 1'b0;
         tail_done   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         line_cnt    <= '0;
         nf          <= '0;
         r           <= '0;
         v           <= '0;
         full_cnt    <= '0;
         gap_cnt     <= '0;
         tail_issued <= 1'b0;
         cur_tail    <= 1'b0;
         phantom     <= 1'b0;
         seen        <= 1'b0;
         abt_pend    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (frame_start) begin
               state       <= BASE;
               new_base    <= 1'b1;
               busy        <= 1'b1;
               nf          <= line_beats / LSIZE'(BURST_LEN);
               r           <= line_beats % LSIZE'(BURST_LEN);
               v           <= vactive;
               line_cnt    <= '0;
               full_cnt    <= '0;
               tail_issued <= 1'b0;
               abt_pend    <= 1'b0;
            end
            BASE: begin
               new_base <= 1'b0;
               state    <= GAP;
               gap_cnt  <= 8'(SETTLE - 1);
            end
            GAP: if (abort_exit) begin
               state      <= DONE;
               frame_done <= 1'b1;
            end else if (gap_cnt != '0) begin
               gap_cnt <= gap_cnt - 1'b1;
            end else if (frame_end) begin
               state      <= DONE;
               frame_done <= 1'b1;
            end else begin
               state    <= REQ;
               cur_tail <= !full_left;
               phantom  <= !full_left && !tail_left;
               req      <= full_left || tail_left;
               req_len  <= full_left ? 8'(BURST_LEN - 1) : tail_left ? 8'(r - 1'b1) : 8'd0;
            end
            REQ: if (ack) begin
               state   <= WAIT;
               req     <= 1'b0;
               phantom <= 1'b0;
               seen    <= xfer_done || phantom;
               if (cur_tail) tail_issued <= 1'b1;
               else full_cnt <= full_cnt + 1'b1;
            end else if (abort_exit) begin
               state      <= DONE;
               req        <= 1'b0;
               frame_done <= 1'b1;
            end
            WAIT: begin
               if (abt) abt_pend <= 1'b1;
               if (xfer_done || seen) begin
                  state      <= PULSE;
                  seen       <= 1'b0;
                  burst_done <= !cur_tail;
                  tail_done  <= cur_tail;
                  if (cur_tail) begin
                     line_cnt    <= line_cnt + 1'b1;
                     full_cnt    <= '0;
                     tail_issued <= 1'b0;
                  end
               end
            end
            PULSE: begin
               burst_done <= 1'b0;
               tail_done  <= 1'b0;
               if (abort_exit) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else begin
                  state   <= GAP;
                  gap_cnt <= 8'(SETTLE - 1);
               end
            end
            default: begin
               state      <= IDLE;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               abt_pend   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SCHED_ABORT_EN
   // mark the frame_done pulse of a frame that ended through abort
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) aborted <= 1'b0;
      else aborted <= abort_exit;
   end
`endif
endmodule
